// File: rtl/gf180mcu_fd_sc_mcu7t5v0__nor_filt_pkg.sv
// Shared types and limits for the filtered NOR cell.
// Holds the FSM state encoding, parameter limits and synchroniser depth.
package gf180mcu_fd_sc_mcu7t5v0__nor_filt_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        QUAL   = 2'd1,
        ACTIVE = 2'd2
    } state_e;

    localparam int WIDTH_MAX   = 32;
    localparam int FILT_MAX    = 255;
    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__nor_filt_sync.sv
// WIDTH-bit, SYNC_STAGES-deep synchroniser; every flop resets to one.
// Ports: CLK, RN (async low), d (async in), q (synchronised out).
module gf180mcu_fd_sc_mcu7t5v0__nor_filt_sync
    import gf180mcu_fd_sc_mcu7t5v0__nor_filt_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] stg;

    // Reset to ones so the NOR reads "not all clear" until real
    // samples have propagated through the chain.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            stg <= '1;
        end else begin
            stg <= {stg[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stg[SYNC_STAGES-1];

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__nor_filt.sv
// Clocked WIDTH-input NOR with FILT-sample qualification filter.
// Ports: CLK, RN (async low), A[WIDTH], EN -> ZN, ZN_PULSE; VDD/VSS supply.
// Macro GF180MCU_NOR_FILT_SYNC_EN inserts a 2-flop synchroniser on A.
module gf180mcu_fd_sc_mcu7t5v0__nor_filt
    import gf180mcu_fd_sc_mcu7t5v0__nor_filt_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int FILT  = 3
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic [WIDTH-1:0] A,
    input  logic             EN,
    output logic             ZN,
    output logic             ZN_PULSE,
    inout  wire              VDD,
    inout  wire              VSS
);

    localparam int CW = $clog2(FILT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FILT);

    if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_bad_width
        $fatal(1, "nor_filt: WIDTH %0d out of range", WIDTH);
    end
    if (FILT < 1 || FILT > FILT_MAX) begin : g_bad_filt
        $fatal(1, "nor_filt: FILT %0d out of range", FILT);
    end

    // Supply pins carry no logic function.
    wire unused_supply = VDD ^ VSS;

    logic [WIDTH-1:0] a_s;

`ifdef GF180MCU_NOR_FILT_SYNC_EN
    gf180mcu_fd_sc_mcu7t5v0__nor_filt_sync #(
        .WIDTH (WIDTH)
    ) u_sync (
        .CLK (CLK),
        .RN  (RN),
        .d   (A),
        .q   (a_s)
    );
`else
    assign a_s = A;
`endif

    logic all_low;
    assign all_low = EN & ~|a_s;

    state_e        state, nstate;
    logic [CW-1:0] cnt, ncnt;
    logic          zn_d, pulse_d;

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state    <= IDLE;
            cnt      <= '0;
            ZN       <= 1'b0;
            ZN_PULSE <= 1'b0;
        end else begin
            state    <= nstate;
            cnt      <= ncnt;
            ZN       <= zn_d;
            ZN_PULSE <= pulse_d;
        end
    end

    // Any high sample (or EN low) drops straight to IDLE with no
    // partial credit kept; the counter saturates at FILT in ACTIVE.
    always_comb begin
        nstate = state;
        ncnt   = cnt;
        unique case (state)
            IDLE: begin
                if (all_low) begin
                    if (FILT == 1) begin
                        nstate = ACTIVE;
                        ncnt   = CNT_FULL;
                    end else begin
                        nstate = QUAL;
                        ncnt   = CW'(1);
                    end
                end
            end
            QUAL: begin
                if (!all_low) begin
                    nstate = IDLE;
                    ncnt   = '0;
                end else if (cnt == CNT_LAST) begin
                    nstate = ACTIVE;
                    ncnt   = CNT_FULL;
                end else begin
                    ncnt = cnt + CW'(1);
                end
            end
            ACTIVE: begin
                if (!all_low) begin
                    nstate = IDLE;
                    ncnt   = '0;
                end
            end
            default: begin
                nstate = IDLE;
                ncnt   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so ZN and the
    // strobe land on the same edge as the ACTIVE entry.
    always_comb begin
        zn_d    = (nstate == ACTIVE);
        pulse_d = (nstate == ACTIVE) && (state != ACTIVE);
    end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__nor_filt.sv
// Directed bench for the filtered NOR cell.
// Table-driven main sequence plus hand-written multi-cycle cases.
module tb_gf180mcu_fd_sc_mcu7t5v0__nor_filt;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rn = 1'b0;
    logic        en0 = 1'b1;
    logic        en_o = 1'b1;
    logic [3:0]  a0 = 4'hf;
    logic [31:0] a32 = '1;
    logic [3:0]  a1 = 4'hf;
    logic [3:0]  a255 = 4'hf;
    wire         vdd = 1'b1;
    wire         vss = 1'b0;

    logic zn0, pl0, zn32, pl32, zn1, pl1, zn255, pl255;

    int checks = 0;
    int errors = 0;

    gf180mcu_fd_sc_mcu7t5v0__nor_filt #(.WIDTH(4), .FILT(3)) u0 (
        .CLK(clk), .RN(rn), .A(a0), .EN(en0),
        .ZN(zn0), .ZN_PULSE(pl0), .VDD(vdd), .VSS(vss));

    gf180mcu_fd_sc_mcu7t5v0__nor_filt #(.WIDTH(32), .FILT(3)) u32 (
        .CLK(clk), .RN(rn), .A(a32), .EN(en_o),
        .ZN(zn32), .ZN_PULSE(pl32), .VDD(vdd), .VSS(vss));

    gf180mcu_fd_sc_mcu7t5v0__nor_filt #(.WIDTH(4), .FILT(1)) u1 (
        .CLK(clk), .RN(rn), .A(a1), .EN(en_o),
        .ZN(zn1), .ZN_PULSE(pl1), .VDD(vdd), .VSS(vss));

    gf180mcu_fd_sc_mcu7t5v0__nor_filt #(.WIDTH(4), .FILT(255)) u255 (
        .CLK(clk), .RN(rn), .A(a255), .EN(en_o),
        .ZN(zn255), .ZN_PULSE(pl255), .VDD(vdd), .VSS(vss));

    typedef struct {
        logic       rn;
        logic       en;
        logic [3:0] a;
        logic       zn;
        logic       pl;
    } vec_t;

    vec_t tbl[22];

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 4'h0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 4'h0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 4'h0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 4'h0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 4'h0, 1'b1, 1'b1};
        tbl[5]  = '{1'b1, 1'b1, 4'h0, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 4'h8, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 4'h0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 4'h0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 4'h4, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 4'h0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 4'h0, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 4'h0, 1'b1, 1'b1};
        tbl[13] = '{1'b1, 1'b1, 4'h0, 1'b1, 1'b0};
        tbl[14] = '{1'b1, 1'b1, 4'h1, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 1'b1, 4'h0, 1'b0, 1'b0};
        tbl[16] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0};
        tbl[17] = '{1'b1, 1'b1, 4'h0, 1'b0, 1'b0};
        tbl[18] = '{1'b1, 1'b1, 4'h0, 1'b0, 1'b0};
        tbl[19] = '{1'b1, 1'b1, 4'h0, 1'b1, 1'b1};
        tbl[20] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0};
        tbl[21] = '{1'b1, 1'b1, 4'hf, 1'b0, 1'b0};

        #2;
        chk("rst_zn0", zn0, 1'b0);
        chk("rst_pl0", pl0, 1'b0);
        chk("rst_zn255", zn255, 1'b0);

`ifndef GF180MCU_NOR_FILT_SYNC_EN
        // Main table on the WIDTH=4, FILT=3 instance.
        for (int i = 0; i < 22; i++) begin
            rn  = tbl[i].rn;
            en0 = tbl[i].en;
            a0  = tbl[i].a;
            step();
            chk($sformatf("tbl%0d_zn", i), zn0, tbl[i].zn);
            chk($sformatf("tbl%0d_pl", i), pl0, tbl[i].pl);
        end

        // Async reset mid-ACTIVE, then full requalification.
        a0 = 4'h0;
        repeat (3) step();
        chk("pre_rst_zn", zn0, 1'b1);
        #2 rn = 1'b0;
        #1;
        chk("async_rst_zn", zn0, 1'b0);
        step();
        rn = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk($sformatf("rel_e%0d_zn", k), zn0, k == 3);
            chk($sformatf("rel_e%0d_pl", k), pl0, k == 3);
        end

        // Deassert on every bit of the 32-wide instance.
        for (int b = 0; b < 32; b++) begin
            a32 = '0;
            repeat (3) step();
            chk($sformatf("w32_up%0d", b), zn32, 1'b1);
            a32 = 32'h1 << b;
            step();
            chk($sformatf("w32_dn%0d_zn", b), zn32, 1'b0);
            chk($sformatf("w32_dn%0d_pl", b), pl32, 1'b0);
        end

        // FILT=1: rises on the first all-low edge.
        a1 = 4'h0;
        step();
        chk("f1_zn", zn1, 1'b1);
        chk("f1_pl", pl1, 1'b1);
        step();
        chk("f1_pl_clr", pl1, 1'b0);
        a1 = 4'h2;
        step();
        chk("f1_dn", zn1, 1'b0);

        // FILT=255: rises on edge 255, then holds for 1000 edges.
        a255 = 4'h0;
        for (int k = 1; k <= 255; k++) begin
            step();
            chk($sformatf("f255_e%0d_zn", k), zn255, k == 255);
            chk($sformatf("f255_e%0d_pl", k), pl255, k == 255);
        end
        for (int k = 0; k < 1000; k++) begin
            step();
            chk($sformatf("f255_hold%0d_zn", k), zn255, 1'b1);
            chk($sformatf("f255_hold%0d_pl", k), pl255, 1'b0);
        end
        a255 = 4'h1;
        step();
        chk("f255_dn", zn255, 1'b0);
`else
        // Synchroniser adds two edges on the A path.
        a0 = 4'h0;
        step();
        rn = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk($sformatf("sync_e%0d_zn", k), zn0, k == 5);
            chk($sformatf("sync_e%0d_pl", k), pl0, k == 5);
        end
        // A rise reaches ZN after 1 + 2 edges.
        a0 = 4'h2;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk($sformatf("sync_dn%0d", k), zn0, k != 3);
        end
        // EN path bypasses the synchroniser.
        a0 = 4'h0;
        repeat (5) step();
        chk("sync_up2", zn0, 1'b1);
        en0 = 1'b0;
        step();
        chk("sync_en_dn", zn0, 1'b0);
        en0 = 1'b1;
        // Reset mid-QUAL restarts through the reset-to-one chain.
        step();
        chk("sync_qual_zn", zn0, 1'b0);
        #2 rn = 1'b0;
        #1;
        chk("sync_rst_zn", zn0, 1'b0);
        step();
        rn = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk($sformatf("sync_rel%0d_zn", k), zn0, k == 5);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__nor_filt.md
# gf180mcu_fd_sc_mcu7t5v0__nor_filt

Parametrised, clocked N-input NOR with a digital qualification filter. ZN asserts only after every input has been low for FILT consecutive clock samples, and drops on the first sample with any input high. It is the next generation after the fixed 4-input combinational NOR cells in the mcu7t5v0 library. Intended use is wake-up, idle and all-clear detection in the MCU always-on domain, where a raw NOR glitches on input skew.

## Interface
Parameters:
- WIDTH, 4: number of NOR inputs; legal range 1..32.
- FILT, 3: consecutive all-low samples required before ZN asserts; legal range 1..255.

Ports:
- CLK  input  1  rising-edge clock.
- RN  input  1  reset; asynchronous, active-low; clears all state.
- A  input  WIDTH  NOR inputs; A[0] corresponds to A1 of the fixed cells.
- EN  input  1  filter enable; low forces IDLE.
- ZN  output  1  registered, filtered NOR of A.
- ZN_PULSE  output  1  one-cycle strobe on each ZN rise.
- VDD  inout  1  supply; no logic function.
- VSS  inout  1  ground; no logic function.

## Operation
- Sample vector `a_s` is A. With synchroniser configuration it is the synchronised A (see Configuration).
- `all_low = EN & ~|a_s`.
- Counter `cnt` is $clog2(FILT+1) bits wide. It saturates at FILT and never wraps.
- State machine, one transition per rising CLK edge:
  - IDLE: ZN=0, cnt=0.
    - If all_low and FILT==1, go to ACTIVE.
    - Else if all_low, go to QUAL with cnt=1.
  - QUAL: ZN=0.
    - If !all_low, go to IDLE with cnt=0.
    - Else if cnt==FILT-1, go to ACTIVE.
    - Else cnt++.
  - ACTIVE: ZN=1, cnt held at FILT.
    - If !all_low, go to IDLE with cnt=0.
- ZN_PULSE=1 exactly on the cycle following an IDLE/QUAL→ACTIVE transition. It is 0 otherwise.
- EN low takes priority in every state. The next edge goes to IDLE. ZN=0 follows that edge, and no ZN_PULSE is generated.
- A single high sample in QUAL restarts qualification from zero. No partial credit is kept.
- WIDTH==1 degenerates to a filtered inverter. No special casing is needed.

## Timing
- Reset (RN low): state=IDLE, cnt=0, ZN=0, ZN_PULSE=0, synchroniser flops=all ones. All take effect immediately and asynchronously.
- Reset release: the first edge with RN high is evaluated normally.
- RN asserted mid-QUAL or mid-ACTIVE: ZN drops asynchronously. Qualification restarts from zero after release.
- Assert latency: ZN rises on the FILT-th edge that samples all_low=1 consecutively. With the synchroniser, add 2 edges.
- Deassert latency: ZN falls on the first edge that samples any A bit high or EN low. With the synchroniser, the A path adds 2 edges; the EN path adds none.
- ZN and ZN_PULSE are driven directly from flops, with no combinational path from A or EN.
- An input glitch shorter than one clock period that lands between edges is invisible.

## Configuration
- Macro: GF180MCU_NOR_FILT_SYNC_EN.
- Defined: each A bit passes through a 2-flop synchroniser clocked by CLK, reset to 1 by RN. Asynchronous A is allowed. Latency is as stated in Timing, plus 2 on the A path.
- Undefined: A is sampled directly and must be synchronous to CLK. The synchroniser adds no area and no latency.

## Structure
- Package gf180mcu_fd_sc_mcu7t5v0__nor_filt_pkg contains:
  - the state enum (IDLE, QUAL, ACTIVE), 2-bit encoding;
  - constants WIDTH_MAX=32 and FILT_MAX=255;
  - the synchroniser depth constant SYNC_STAGES=2.
- Sub-module gf180mcu_fd_sc_mcu7t5v0__nor_filt_sync holds the WIDTH-bit, SYNC_STAGES-deep synchroniser with reset-to-one. It is instantiated only under the macro.
- The top level holds the state machine, counter and output flops.
- Parameter legality is checked at elaboration and is fatal when out of range.

## Test plan
- Reset: WIDTH=4, FILT=3, RN low with A=4'b0000 → ZN=0, ZN_PULSE=0. After release with A held 0, ZN=1 on the 3rd edge, and ZN_PULSE=1 for exactly that one cycle.
- Glitch reject: FILT=3, A=0 for 2 edges, then A=4'b0100 for 1 edge, then 0 → ZN rises only on the 3rd edge after the glitch, never earlier.
- Deassert: in ACTIVE, set A=4'b1000 → ZN=0 after the next edge and ZN_PULSE stays 0. Repeat for every bit of WIDTH=32.
- EN priority: in QUAL, pull EN low for 1 edge with A=0 → IDLE. ZN then needs a full 3 further edges with EN high.
- FILT=1 and FILT=255 extremes: ZN rises on the 1st and the 255th all-low edge respectively. The counter does not wrap when A is held 0 for 1000 edges.
- Sync macro defined: A falls to 0 → ZN rises at FILT+2 edges. RN asserted mid-QUAL → ZN=0 and qualification restarts after release.
